// File: rtl/instr_aligner_if.sv
// Fetch/flush/decode bundle between fetch, aligner and decode.
// The aligner connects on the slave modport.
interface instr_aligner_if;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic [31:0] fetch_pc;
  logic        flush;
  logic [31:0] flush_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_compressed;

  modport master (
    output fetch_valid,
    input  fetch_ready,
    output fetch_data,
    output fetch_pc,
    output flush,
    output flush_pc,
    input  dec_valid,
    output dec_ready,
    input  dec_instr,
    input  dec_pc,
    input  dec_compressed
  );

  modport slave (
    input  fetch_valid,
    output fetch_ready,
    input  fetch_data,
    input  fetch_pc,
    input  flush,
    input  flush_pc,
    output dec_valid,
    input  dec_ready,
    output dec_instr,
    output dec_pc,
    output dec_compressed
  );
endinterface

// File: rtl/instr_aligner.sv
// Halfword queue that re-assembles 16/32-bit instructions
// from word-aligned fetch packets, one instruction per transfer.
module instr_aligner #(
  parameter int HQ_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  instr_aligner_if.slave bus
);

  localparam int AW = (HQ_DEPTH > 1) ? $clog2(HQ_DEPTH) : 1;
  localparam int CW = $clog2(HQ_DEPTH) + 1;

  typedef struct packed {
    logic [15:0] data;
    logic [31:0] pc;
  } hw_t;

  hw_t           q [HQ_DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic          skip_low;

  function automatic logic [AW-1:0] inc1(
    input logic [AW-1:0] p
  );
    if (p == AW'(HQ_DEPTH - 1))
      return '0;
    else
      return p + 1'b1;
  endfunction

  function automatic logic [AW-1:0] inc2(
    input logic [AW-1:0] p
  );
    return inc1(inc1(p));
  endfunction

  hw_t           h0;
  hw_t           h1;
  logic          h0_c;
  logic          valid;
  logic          enq;
  logic          deq;
  logic [CW-1:0] enq_amt;
  logic [CW-1:0] deq_amt;
  logic [CW-1:0] count_next;
  logic [31:0]   base_pc;
  logic [31:0]   upper_pc;
  hw_t           lo_hw;
  hw_t           hi_hw;

  assign h0   = q[head];
  assign h1   = q[inc1(head)];
  assign h0_c = (h0.data[1:0] != 2'b11);

  // A 32-bit head needs both halves resident before it is offered
  assign valid = h0_c ? (count != '0)
                      : (count >= CW'(2));

  assign bus.fetch_ready = (count <= CW'(HQ_DEPTH - 2));
  assign bus.dec_valid   = valid;
  assign bus.dec_compressed = valid & h0_c;
  assign bus.dec_pc      = valid ? h0.pc : '0;

  always_comb begin
    bus.dec_instr = '0;
    if (valid) begin
      if (h0_c)
        bus.dec_instr = {16'h0, h0.data};
      else
        bus.dec_instr = {h1.data, h0.data};
    end
  end

  assign enq = bus.fetch_valid & bus.fetch_ready
             & ~bus.flush;
  assign deq = valid & bus.dec_ready & ~bus.flush;

  assign base_pc  = {bus.fetch_pc[31:2], 2'b00};
  assign upper_pc = base_pc + 32'd2;
  assign lo_hw    = '{data: bus.fetch_data[15:0],
                      pc:   base_pc};
  assign hi_hw    = '{data: bus.fetch_data[31:16],
                      pc:   upper_pc};

  always_comb begin
    enq_amt = '0;
    if (enq)
      enq_amt = skip_low ? CW'(1) : CW'(2);
  end

  always_comb begin
    deq_amt = '0;
    if (deq)
      deq_amt = h0_c ? CW'(1) : CW'(2);
  end

  assign count_next = count + enq_amt - deq_amt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HQ_DEPTH; i++)
        q[i] <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      skip_low <= 1'b0;
    end else if (bus.flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      skip_low <= bus.flush_pc[1];
    end else begin
      if (enq) begin
        if (skip_low) begin
          q[tail]  <= hi_hw;
          tail     <= inc1(tail);
          skip_low <= 1'b0;
        end else begin
          q[tail]       <= lo_hw;
          q[inc1(tail)] <= hi_hw;
          tail          <= inc2(tail);
        end
      end
      if (deq)
        head <= h0_c ? inc1(head) : inc2(head);
      count <= count_next;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.fetch_pc[1:0],
                         bus.flush_pc[31:2],
                         bus.flush_pc[0]};

endmodule
